// File: rtl/adc_sample_rx.sv
// adc_sample_rx: periodic 12-bit SPI ADC capture to signed 16-bit left-justified samples; ADC_RX_FRAME_CHECK_EN enables the leading-zero frame check
module adc_sample_rx #(
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_DIV = 450
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        adc_sdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        busy,
  output logic        overrun,
  output logic        frame_err
);
  localparam int TW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [DW-1:0] div, div_nx;
  logic [3:0] bit_cnt, bit_nx;
  logic [15:0] shreg, sh_nx;
  logic sclk_nx, trig, tick, done;
  assign trig = en && timer == TW'(SAMPLE_DIV - 1);
  assign tick = div == DW'(CLK_DIV - 1);
  assign done = state == HOLD && tick;
  assign busy = ~adc_cs_n;
  // sample timer: free-runs while enabled, wrap is the conversion trigger
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else if (en) timer <= trig ? '0 : timer + TW'(1);
  // frame sequencing; each phase lasts one CLK_DIV tick, data sampled as sclk rises
  always_comb begin
    state_nx = state;
    div_nx   = (state == IDLE || tick) ? '0 : div + DW'(1);
    bit_nx   = bit_cnt;
    sh_nx    = shreg;
    sclk_nx  = adc_sclk;
    case (state)
      IDLE:  if (trig) begin
        state_nx = SETUP;
        bit_nx   = '0;
      end
      SETUP: if (tick) begin
        state_nx = SHIFT;
        sclk_nx  = 1'b0;
      end
      SHIFT: if (tick) begin
        if (!adc_sclk) begin
          sclk_nx = 1'b1;
          sh_nx   = {shreg[14:0], adc_sdata};
        end else if (bit_cnt == 4'd15) state_nx = HOLD;
        else begin
          sclk_nx = 1'b0;
          bit_nx  = bit_cnt + 4'd1;
        end
      end
      default: if (tick) state_nx = IDLE;
    endcase
  end
  // state, serial interface and sample output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      adc_sclk   <= 1'b1;
      adc_cs_n   <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      div        <= div_nx;
      bit_cnt    <= bit_nx;
      shreg      <= sh_nx;
      adc_sclk   <= sclk_nx;
      adc_cs_n   <= state_nx == IDLE;
      dout_valid <= done;
      overrun    <= trig && state != IDLE;
      if (done) dout <= {~shreg[11], shreg[10:0], 4'b0000};
    end
`ifdef ADC_RX_FRAME_CHECK_EN
  // leading four bits of a valid frame are zero; flag otherwise alongside dout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_err <= 1'b0;
    else if (done) frame_err <= |shreg[15:12];
`else
  assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_adc_sample_rx.sv
// tb_adc_sample_rx: scoreboard bench for adc_sample_rx with an SPI ADC model
module tb_adc_sample_rx;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, en2 = 1'b0, sdata = 1'b0;
  logic cs_n, sclk, dv, busy, ovr, ferr;
  logic cs_n2, sclk2, dv2, busy2, ovr2, ferr2;
  logic [15:0] dout, dout2;
  logic [15:0] frame = '0;
  logic [16:0] exp_q[$];
  logic [16:0] e;
  logic pdv = 1'b0, povr = 1'b0, povr2 = 1'b0;
  int checks = 0, errors = 0, cyc = 0, last_fall = 0, idx = 15;
`ifdef ADC_RX_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  adc_sample_rx u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .adc_sdata(sdata), .adc_cs_n(cs_n), .adc_sclk(sclk),
    .dout(dout), .dout_valid(dv), .busy(busy), .overrun(ovr), .frame_err(ferr)
  );
  adc_sample_rx #(.CLK_DIV(2), .SAMPLE_DIV(60)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .adc_sdata(1'b0), .adc_cs_n(cs_n2), .adc_sclk(sclk2),
    .dout(dout2), .dout_valid(dv2), .busy(busy2), .overrun(ovr2), .frame_err(ferr2)
  );
  // ADC model: next bit presented after every sclk fall, MSB first
  always @(negedge cs_n) idx = 15;
  always @(negedge sclk) if (!cs_n && idx >= 0) begin
    sdata = frame[idx];
    idx = idx - 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // monitor: pop expected sample on every dout_valid and check pulse widths
  always @(posedge clk) begin
    #1;
    if (dv) begin
      chk("valid_expected", exp_q.size() != 0, 1);
      chk("valid_width", pdv, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout", dout, e[15:0]);
        chk("frame_err", ferr, e[16]);
      end
    end
    if (ovr) chk("u1_overrun", ovr, 0);
    if (ovr2) chk("overrun_width", povr2, 0);
    pdv = dv;
    povr = ovr;
    povr2 = ovr2;
  end
  task automatic run_frame(input logic [15:0] f, input logic [15:0] ed, input logic ef,
                           input int drop_at, input bit chk_period);
    int n, low, rises, bad, lr;
    logic ps;
    frame = f;
    exp_q.push_back({ef & FC, ed});
    n = 0;
    while (cs_n && n < 1000) begin
      tick();
      n++;
    end
    chk("cs_fall_timeout", cs_n, 0);
    if (cs_n) return;
    chk("busy", busy, 1);
    if (chk_period) chk("period", cyc - last_fall, 450);
    last_fall = cyc;
    low = 1; rises = 0; bad = 0; lr = 0; ps = sclk;
    while (1) begin
      tick();
      if (cs_n || low >= 200) break;
      low++;
      if (sclk && !ps) begin
        if (rises > 0 && cyc - lr != 4) bad++;
        lr = cyc;
        rises++;
      end
      ps = sclk;
      if (low == drop_at) en = 1'b0;
    end
    chk("cs_low_clks", low, 68);
    chk("sclk_rises", rises, 16);
    chk("sclk_spacing", bad, 0);
    chk("valid_at_cs_rise", dv, 1);
  endtask
  initial begin
    int n, falls, oc, vc;
    logic ps;
    repeat (3) tick();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_frame_err", ferr, 0);
    rst_n = 1'b1;
    en = 1'b1;
    run_frame(16'h0800, 16'h0000, 1'b0, -1, 1'b0);
    run_frame(16'h0FFF, 16'h7FF0, 1'b0, -1, 1'b1);
    run_frame(16'h0000, 16'h8000, 1'b0, -1, 1'b1);
    run_frame(16'h4ABC, 16'h2BC0, 1'b1, -1, 1'b1);
    run_frame(16'hF123, 16'h9230, 1'b1, -1, 1'b1);
    run_frame(16'h0123, 16'h9230, 1'b0, 24, 1'b1);
    falls = 0;
    repeat (1350) begin
      ps = cs_n;
      tick();
      if (ps && !cs_n) falls++;
    end
    chk("no_trigger_en0", falls, 0);
    en = 1'b1;
    run_frame(16'h0ABC, 16'h2BC0, 1'b0, -1, 1'b0);
    frame = 16'h0FFF;
    n = 0;
    while (cs_n && n < 1000) begin
      tick();
      n++;
    end
    chk("rst_test_fall", cs_n, 0);
    repeat (34) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_sclk", sclk, 1);
    chk("midrst_dout", dout, 0);
    chk("midrst_valid", dv, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    run_frame(16'h0FFF, 16'h7FF0, 1'b0, -1, 1'b0);
    en = 1'b0;
    en2 = 1'b1;
    oc = 0;
    vc = 0;
    repeat (400) begin
      tick();
      if (ovr2) oc++;
      if (dv2) begin
        vc++;
        chk("u2_dout", dout2, 16'h8000);
      end
    end
    chk("u2_overruns", oc, 3);
    chk("u2_frames", vc, 3);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #800000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
endmodule
